// File: rtl/packet_arbiter_pkg.sv
// Shared widths, FSM state and packet layout for the two-input packet arbiter.
package packet_arbiter_pkg;

    localparam int HDR_W    = 16;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int LOCK_BIT = 15;
    localparam int CNT_W    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic [HDR_W-1:0]  header;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pkt_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_select2.sv
// Two-way round-robin selector with a lock override; purely combinational.
module rr_select2
    import packet_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       locked,
    input  logic       lock_src,
    output logic [1:0] sel
);

    always_comb begin
        sel = 2'b00;
        if (locked)
            // The lock holder stays selected even while it has nothing to send.
            sel = onehot2(lock_src);
        else if (&valid)
            sel = onehot2(~last_grant);
        else
            sel = valid;
    end

endmodule

// File: rtl/packet_arbiter.sv
// Two-requester packet arbiter: round-robin with header-driven lock, one output register.
module packet_arbiter
    import packet_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [HDR_W-1:0]  in0_tx_header,
    input  logic [ADDR_W-1:0] in0_tx_addr,
    input  logic [DATA_W-1:0] in0_tx_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [HDR_W-1:0]  in1_tx_header,
    input  logic [ADDR_W-1:0] in1_tx_addr,
    input  logic [DATA_W-1:0] in1_tx_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic [HDR_W-1:0]  outPacket_rx_header,
    output logic [ADDR_W-1:0] outPacket_rx_addr,
    output logic [DATA_W-1:0] outPacket_rx_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  grant_cnt
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             lock_src_q, lock_src_d;
    logic             out_valid_q, out_valid_d;
    pkt_t             pkt_q, pkt_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    logic [1:0] valid, sel, ready, acc;
    logic       free, src;
    pkt_t       in_pkt;

    assign valid = {in1_valid, in0_valid};

    rr_select2 u_sel (
        .valid      (valid),
        .last_grant (last_grant_q),
        .locked     (state_q == LOCKED),
        .lock_src   (lock_src_q),
        .sel        (sel)
    );

    // Drain-and-refill in one cycle keeps throughput at one packet per clock.
    assign free   = ~out_valid_q | out_ready;
    assign ready  = (reset_n && free) ? sel : 2'b00;
    assign acc    = ready & valid;
    assign src    = acc[1];
    assign in_pkt = src ? pkt_t'{in1_tx_header, in1_tx_addr, in1_tx_data}
                        : pkt_t'{in0_tx_header, in0_tx_addr, in0_tx_data};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_src_d   = lock_src_q;
        out_valid_d  = out_valid_q;
        pkt_d        = pkt_q;
        grant_cnt_d  = grant_cnt_q;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (|acc) begin
            out_valid_d  = 1'b1;
            pkt_d        = in_pkt;
            grant_cnt_d  = grant_cnt_q + 1'b1;
            last_grant_d = src;
            if (in_pkt.header[LOCK_BIT]) begin
                state_d    = LOCKED;
                lock_src_d = src;
            end else begin
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lock_src_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            pkt_q        <= '0;
            grant_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_src_q   <= lock_src_d;
            out_valid_q  <= out_valid_d;
            pkt_q        <= pkt_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign in0_ready           = ready[0];
    assign in1_ready           = ready[1];
    assign out_valid           = out_valid_q;
    assign outPacket_rx_header = pkt_q.header;
    assign outPacket_rx_addr   = pkt_q.addr;
    assign outPacket_rx_data   = pkt_q.data;
    assign grant_cnt           = grant_cnt_q;

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 The block SHALL be clocked by one clock and reset asynchronously, active-low; no other clock or reset exists.
REQ-002 Port `clock`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port `reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Ports `in0_tx_header` [15:0], `in0_tx_addr` [15:0], `in0_tx_data` [31:0], all inputs: requester 0 packet.
REQ-005 Port `in0_valid`, input, 1 bit: requester 0 packet present. Port `in0_ready`, output, 1 bit: requester 0 packet accepted this cycle.
REQ-006 Ports `in1_tx_header`, `in1_tx_addr`, `in1_tx_data`, `in1_valid` (inputs) and `in1_ready` (output): requester 1, with the same widths and meaning.
REQ-007 Ports `outPacket_rx_header` [15:0], `outPacket_rx_addr` [15:0], `outPacket_rx_data` [31:0], all outputs: registered packet.
REQ-008 Port `out_valid`, output, 1 bit: output register holds a packet. Port `out_ready`, input, 1 bit: downstream takes the packet.
REQ-009 Port `grant_cnt`, output, 16 bits: count of packets accepted since reset.

Function
REQ-010 A transfer SHALL occur on an input when `valid` && `ready` are both high in one cycle, and on the output when `out_valid` && `out_ready` are both high in one cycle.
REQ-011 The output register SHALL be free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 (drain and refill in the same cycle).
REQ-012 At most one `inN_ready` SHALL be high per cycle. It SHALL be high only when the register is free and N is the selected requester; `ready` SHALL NOT depend on that requester's own `valid` other than through selection.
REQ-013 The FSM SHALL have two states:
- IDLE: round-robin selection. With one requester valid, that requester is selected. With both valid, the requester other than `last_grant` is selected.
- LOCKED: only `lock_src` is selected; the other requester is stalled even if valid.
REQ-014 Header bit 15 = 1 on an accepted packet SHALL move the FSM to LOCKED with `lock_src` = the accepting requester. An accepted packet with bit 15 = 0 SHALL return the FSM to IDLE.
REQ-015 In LOCKED, if `lock_src` drops `valid`, the FSM SHALL remain LOCKED (no timeout).
REQ-016 On every accepted packet, `last_grant` SHALL be set to the accepting requester.
REQ-017 An accepted packet SHALL appear on the `outPacket_rx_*` ports with `out_valid`=1 on the next cycle; latency is 1 cycle.
REQ-018 Header, addr and data SHALL be passed unmodified, including header bit 15.
REQ-019 While `out_valid`=1 and `out_ready`=0, the output ports SHALL hold stable and both `ready` signals SHALL be 0.
REQ-020 If no packet is accepted in a cycle where the output drains, `out_valid` SHALL fall to 0 on the next cycle.
REQ-021 `grant_cnt` SHALL increment by 1 per accepted packet and wrap from 0xFFFF to 0x0000.
REQ-022 Sustained throughput SHALL be 1 packet per cycle when `out_ready`=1.

Reset
REQ-023 While `reset_n`=0, the following SHALL hold:
- FSM = IDLE
- `last_grant` = 1, so requester 0 wins the first tie
- `lock_src` = 0
- `out_valid` = 0
- `outPacket_rx_*` = 0
- `grant_cnt` = 0
- `in0_ready` = `in1_ready` = 0
REQ-024 A reset asserted mid-packet or while LOCKED SHALL discard the held packet and the lock, with no partial output.
REQ-025 After `reset_n` rises, acceptance SHALL be possible on the first clock edge.

Structure
REQ-026 A shared package SHALL define:
- widths HDR_W=16, ADDR_W=16, DATA_W=32
- LOCK_BIT=15
- the FSM state enum {IDLE, LOCKED}
- a packet struct {header, addr, data}
REQ-027 The selection logic SHALL be one sub-module, `rr_select2`, taking valid[1:0], last_grant, locked and lock_src and returning a one-hot sel[1:0]. The register, FSM and counter SHALL stay in `packet_arbiter`.

Verification
REQ-028 Tie: both valid, `out_ready`=1, headers 0x0001/0x0002 after reset. Required: grants alternate 0,1,0,1; output headers 0x0001, 0x0002, 0x0001…; `grant_cnt` = 4 after 4 cycles.
REQ-029 Lock: in0 sends headers 0x8000, 0x8000, 0x0000 while in1 is valid throughout. Required: in1_ready=0 for those 3 acceptances; in1 is granted on the next cycle.
REQ-030 Backpressure: `out_ready`=0 for 5 cycles with a held packet, addr=0xBEEF. Required: outputs stable, both ready=0; on release the packet is taken and a new one is accepted in that same cycle.
REQ-031 Wrap: force 65536 acceptances. Required: `grant_cnt` returns to 0x0000.
REQ-032 Reset while LOCKED with `out_valid`=1. Required: `out_valid`=0, outputs 0, FSM IDLE; the first post-reset tie goes to in0.
REQ-033 Single requester: only in1 valid, data=0xDEADBEEF. Required: accepted immediately; output appears 1 cycle later with data 0xDEADBEEF.
